// File: rtl/dpb_port_arbiter.sv
// Two-requester arbiter for one single-port RAM.
// Each cycle, at most one requester's beat is passed straight through to the RAM.
// A requester can lock the port for a burst. A locked burst is forcibly released
// after BURST_MAX beats if the other requester is waiting.
// Read data returns one cycle after the grant. A tag bit routes it to the requester
// that issued the read.
module dpb_port_arbiter #(
    parameter int AW        = 13,
    parameter int DW        = 8,
    parameter int BURST_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic [DW-1:0] r1_rdata,
    output logic          ram_ce,
    output logic          ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    output logic          ram_oce,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    // Last beat of a burst; the beat counter never exceeds this value.
    localparam logic [7:0] BC_TOP = 8'(BURST_MAX - 1);

    state_t        state, state_next;
    logic [7:0]    bc, bc_next;
    logic          last, last_next;
    logic          rd_pending, rd_tag;
    logic          gnt0_raw, gnt1_raw;
    logic          g0, g1, g_any, g_lock, g_other;
    logic [1:0]    rvalid_vec;
    logic [DW-1:0] rdata_vec [2];
    logic [DW-1:0] hold [2];

    // Grant selection: round-robin tie-break in IDLE; only the owner may be granted while a burst is locked.
    always_comb begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        case (state)
            IDLE: begin
                if (r0_req && r1_req) begin
                    gnt0_raw = last;
                    gnt1_raw = ~last;
                end else begin
                    gnt0_raw = r0_req;
                    gnt1_raw = r1_req;
                end
            end
            OWN0:    gnt0_raw = r0_req;
            OWN1:    gnt1_raw = r1_req;
            default: ;
        endcase
    end

    // No beat can reach the RAM while reset is held.
    assign g0      = gnt0_raw & rst_n;
    assign g1      = gnt1_raw & rst_n;
    assign g_any   = g0 | g1;
    assign g_lock  = g0 ? r0_lock : r1_lock;
    assign g_other = g0 ? r1_req : r0_req;

    assign r0_gnt  = g0;
    assign r1_gnt  = g1;
    assign ram_ce  = g_any;
    assign ram_wre = g0 ? r0_we : (g1 ? r1_we : 1'b0);
    assign ram_ad  = g0 ? r0_addr : r1_addr;
    assign ram_din = g0 ? r0_wdata : r1_wdata;
    assign ram_oce = 1'b1;

    // Next state: take ownership on a locked beat; release on an unlocked beat or a forced release; count burst beats.
    always_comb begin
        state_next = state;
        bc_next    = bc;
        last_next  = last;
        if (g_any) begin
            last_next = g1;
            if (state == IDLE) begin
                if (g_lock) begin
                    state_next = g0 ? OWN0 : OWN1;
                    bc_next    = 8'd1;
                end
            end else if (!g_lock || (bc == BC_TOP && g_other)) begin
                state_next = IDLE;
                bc_next    = 8'd0;
            end else if (bc != BC_TOP) begin
                bc_next = bc + 8'd1;
            end
        end
    end

    // Register the arbitration state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bc    <= 8'd0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            bc    <= bc_next;
            last  <= last_next;
        end
    end

    // Track which requester owns the read whose data arrives on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            rd_tag     <= 1'b0;
        end else begin
            rd_pending <= g_any & ~ram_wre;
            if (g_any && !ram_wre) rd_tag <= g1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign rvalid_vec[gi] = rd_pending & (rd_tag == 1'(gi));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? ram_dout : hold[gi];

            // Keep the last returned word so rdata stays stable between reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)              hold[gi] <= '0;
                else if (rvalid_vec[gi]) hold[gi] <= ram_dout;
            end
        end
    endgenerate

    assign r0_rvalid = rvalid_vec[0];
    assign r1_rvalid = rvalid_vec[1];
    assign r0_rdata  = rdata_vec[0];
    assign r1_rdata  = rdata_vec[1];

endmodule
